elevator: RTL and testbench
===========================

Name: elevator

Overview:
Controller for a 4-floor elevator (floors 0-3).
- Latches car (internal) and hall (external) floor requests.
- Serves them with a SCAN policy: keep travelling in the current direction while requests remain ahead.
- Drives a one-hot motor/door command plus direction flags.
- Floor position comes from an external sensor input (current_floor); the block does not model car motion itself.

Parameters:
DOOR_CYCLES, 3, number of clk cycles the DOOR_OPEN state is held (legal range 1-255).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset.
current_floor  input  2  floor sensor, 0-3.
buttons_in  input  4  car-panel requests; bit i = floor i; level, sampled every clk.
buttons_out  input  4  hall-call requests; bit i = floor i; level, sampled every clk.
motor  output  4  one-hot command: 0001 IDLE, 0010 UP, 0100 DOWN, 1000 DOOR_OPEN.
dir_up  output  1  high while the car is commanded to move up.
dir_down  output  1  high while the car is commanded to move down.

Behaviour:
- State register values: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- Other registers:
  - pending[3:0]
  - last_dir (1 = up)
  - door counter (8-bit)
- Reset (reset=0, asynchronous):
  - state=IDLE, pending=0000, last_dir=1, counter=0.
  - motor=0001, dir_up=0, dir_down=0.
  - Outputs hold these values for the whole time reset is low.
- Request combining:
  - req = pending | buttons_in | buttons_out (combinational).
  - Every clk: pending <= req, except bit current_floor is forced to 0 when the next state is DOOR_OPEN or the current state is DOOR_OPEN.
  - Net effect: a press at the floor being served is absorbed.
- Helpers: above = any req bit at an index greater than current_floor; below = any req bit at an index less than current_floor.
- Next-state rules (evaluated on req, so the response comes on the first rising edge after a request is presented):
  - IDLE: req[cf] -> DOOR_OPEN; else above -> MOVE_UP; else below -> MOVE_DOWN; else stay.
  - MOVE_UP: req[cf] -> DOOR_OPEN; else above -> stay; else below -> MOVE_DOWN; else IDLE.
  - MOVE_DOWN: symmetric (req[cf] -> DOOR_OPEN; below -> stay; above -> MOVE_UP; else IDLE).
  - DOOR_OPEN: counter increments each cycle; when counter==DOOR_CYCLES-1, clear counter and exit:
    - last_dir=1: above -> MOVE_UP, else below -> MOVE_DOWN, else IDLE.
    - last_dir=0: below first, then above, else IDLE.
  - Counter is cleared on entry to DOOR_OPEN.
- last_dir is updated to 1 on entering MOVE_UP and to 0 on entering MOVE_DOWN.
- Outputs are a registered decode of the state:
  - motor per the one-hot encoding above.
  - dir_up=1 only in MOVE_UP; dir_down=1 only in MOVE_DOWN.
  - Never both high; motor is always exactly one-hot.
- Boundaries:
  - current_floor changing mid-move is simply re-evaluated each cycle.
  - A request at floor 3 while at floor 3 opens the door; no up travel occurs.
  - Simultaneous requests above and below from IDLE: up wins.
  - A held button at the current floor re-opens the door after the dwell period.
  - Reset asserted mid-move returns the block to IDLE immediately and discards all pending requests.

Optional Feature:
Macro: ELEVATOR_PENDING_OUT_EN.
- Defined: adds output port pending_req[3:0], a direct copy of the pending register (reset 0000) for status display or debug.
- Undefined: the port does not exist; internal behaviour is identical.

Test Plan:
- Reset low 2 cycles at floor 0 -> motor=0001, dir_up=0, dir_down=0; release, no buttons -> stays IDLE.
- Floor 0, pulse buttons_out=1000 for 1 cycle -> next edge motor=0010, dir_up=1. Step current_floor 1,2 -> stays UP. At floor 3 -> motor=1000 for 3 cycles, then 0001; pending=0000.
- At floor 3 idle, buttons_in=0110 held -> MOVE_DOWN. current_floor=2 -> DOOR_OPEN, bit 2 cleared. After 3 cycles continues down to floor 1 (last_dir=0), opens, then IDLE once buttons are released.
- At floor 2, buttons_out=0001 -> motor=0100, dir_down=1; floors 1,0 -> door at 0, then IDLE.
- At floor 1 in IDLE, buttons_in=1001 same cycle -> MOVE_UP (up priority). Serve floor 3, then reverse to MOVE_DOWN for floor 0.
- Assert reset while MOVE_UP with pending=1100 -> immediately motor=0001, dir_up=0, pending=0000; after release, no movement.

Source files
------------

// File: rtl/elevator_if.sv
// Sensor/button/command bundle for the elevator controller.
// ELEVATOR_PENDING_OUT_EN adds the pending_req status bus.
interface elevator_if;
    logic [1:0] current_floor;
    logic [3:0] buttons_in;
    logic [3:0] buttons_out;
    logic [3:0] motor;
    logic       dir_up;
    logic       dir_down;
`ifdef ELEVATOR_PENDING_OUT_EN
    logic [3:0] pending_req;

    modport master (output current_floor, buttons_in, buttons_out,
                    input  motor, dir_up, dir_down, pending_req);
    modport slave  (input  current_floor, buttons_in, buttons_out,
                    output motor, dir_up, dir_down, pending_req);
`else
    modport master (output current_floor, buttons_in, buttons_out,
                    input  motor, dir_up, dir_down);
    modport slave  (input  current_floor, buttons_in, buttons_out,
                    output motor, dir_up, dir_down);
`endif
endinterface

// File: rtl/elevator.sv
// 4-floor SCAN elevator controller with registered one-hot motor command.
// ELEVATOR_PENDING_OUT_EN exposes the pending request register on the bus.
module elevator #(
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    elevator_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;
    localparam logic [1:0] S_DOOR = 2'd3;
    localparam logic [7:0] DOOR_LAST = 8'(DOOR_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic       last_dir_q, last_dir_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] motor_q;
    logic       dir_up_q, dir_down_q;

    logic [3:0] req;
    logic [1:0] cf;
    logic       above, below, here;

    assign cf = bus.current_floor;

    always_comb begin
        req   = pending_q | bus.buttons_in | bus.buttons_out;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (i > int'(cf))) above = 1'b1;
            if (req[i] && (i < int'(cf))) below = 1'b1;
        end
        here = req[cf];

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (here)       state_d = S_DOOR;
                else if (above) state_d = S_UP;
                else if (below) state_d = S_DOWN;
            end
            S_UP: begin
                if (here)       state_d = S_DOOR;
                else if (above) state_d = S_UP;
                else if (below) state_d = S_DOWN;
                else            state_d = S_IDLE;
            end
            S_DOWN: begin
                if (here)       state_d = S_DOOR;
                else if (below) state_d = S_DOWN;
                else if (above) state_d = S_UP;
                else            state_d = S_IDLE;
            end
            default: begin
                // Dwell, then resume in the remembered direction first.
                if (cnt_q == DOOR_LAST) begin
                    cnt_d = 8'd0;
                    if (last_dir_q) begin
                        if (above)      state_d = S_UP;
                        else if (below) state_d = S_DOWN;
                        else            state_d = S_IDLE;
                    end else begin
                        if (below)      state_d = S_DOWN;
                        else if (above) state_d = S_UP;
                        else            state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
        if ((state_d == S_DOOR) && (state_q != S_DOOR)) cnt_d = 8'd0;

        // A request at the floor being served is absorbed.
        pending_d = req;
        if ((state_d == S_DOOR) || (state_q == S_DOOR)) pending_d[cf] = 1'b0;

        last_dir_d = last_dir_q;
        if (state_d == S_UP)   last_dir_d = 1'b1;
        if (state_d == S_DOWN) last_dir_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pending_q  <= 4'b0000;
            last_dir_q <= 1'b1;
            cnt_q      <= 8'd0;
            motor_q    <= 4'b0001;
            dir_up_q   <= 1'b0;
            dir_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            last_dir_q <= last_dir_d;
            cnt_q      <= cnt_d;
            motor_q    <= 4'b0001 << state_d;
            dir_up_q   <= (state_d == S_UP);
            dir_down_q <= (state_d == S_DOWN);
        end
    end

    assign bus.motor    = motor_q;
    assign bus.dir_up   = dir_up_q;
    assign bus.dir_down = dir_down_q;
`ifdef ELEVATOR_PENDING_OUT_EN
    assign bus.pending_req = pending_q;
`endif
endmodule

// File: tb/tb_elevator.sv
// Directed test-plan walk plus randomized floor/button traffic for elevator,
// compared against a cycle-level reference model of the SCAN rules.
module tb_elevator;
    localparam int DOOR = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    elevator_if bus();
    elevator #(.DOOR_CYCLES(DOOR)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 going up, 2 going down, 3 door open.
    int         m_mode;
    logic [3:0] m_pend;
    bit         m_up_last;
    int         m_dwell;

    function automatic void model_reset();
        m_mode = 0; m_pend = 4'b0000; m_up_last = 1'b1; m_dwell = 0;
    endfunction

    function automatic void model_step(input int f, input logic [3:0] bi, input logic [3:0] bo);
        logic [3:0] r;
        bit up_req, dn_req, at;
        int nxt;
        r = m_pend | bi | bo;
        up_req = 0; dn_req = 0;
        for (int k = 0; k < 4; k++) begin
            if (r[k] && k > f) up_req = 1;
            if (r[k] && k < f) dn_req = 1;
        end
        at  = r[f];
        nxt = m_mode;
        if (m_mode == 3) begin
            if (m_dwell == DOOR - 1) begin
                m_dwell = 0;
                if (m_up_last) nxt = up_req ? 1 : (dn_req ? 2 : 0);
                else           nxt = dn_req ? 2 : (up_req ? 1 : 0);
            end else m_dwell++;
        end else if (at) begin
            nxt = 3; m_dwell = 0;
        end else if (m_mode == 2) nxt = dn_req ? 2 : (up_req ? 1 : 0);
        else if (m_mode == 1)     nxt = up_req ? 1 : (dn_req ? 2 : 0);
        else                      nxt = up_req ? 1 : (dn_req ? 2 : 0);
        m_pend = r;
        if (nxt == 3 || m_mode == 3) m_pend[f] = 1'b0;
        if (nxt == 1) m_up_last = 1'b1;
        if (nxt == 2) m_up_last = 1'b0;
        m_mode = nxt;
    endfunction

    task automatic check_outputs(input string tag);
        logic [3:0] em;
        em = 4'b0001 << m_mode;
        chk({tag, ".motor"}, bus.motor, em);
        chk({tag, ".dir_up"}, bus.dir_up, m_mode == 1);
        chk({tag, ".dir_down"}, bus.dir_down, m_mode == 2);
`ifdef ELEVATOR_PENDING_OUT_EN
        chk({tag, ".pending"}, bus.pending_req, m_pend);
`endif
    endtask

    // Called at negedge: drive inputs, advance model, check after the edge.
    task automatic cyc(input int f, input logic [3:0] bi, input logic [3:0] bo);
        bus.current_floor = 2'(f);
        bus.buttons_in    = bi;
        bus.buttons_out   = bo;
        if (reset) model_step(f, bi, bo);
        @(posedge clk); #1;
        check_outputs("cyc");
        @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        repeat (n) begin
            @(posedge clk); #1;
            check_outputs("rst_hold");
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    int f;
    logic [3:0] bi, bo;

    initial begin
        reset = 1'b0;
        bus.current_floor = 2'd0; bus.buttons_in = 4'b0; bus.buttons_out = 4'b0;
        model_reset();
        @(negedge clk);
        pulse_reset(2);
        chk("reset_motor", bus.motor, 4'b0001);
        repeat (3) cyc(0, 4'b0, 4'b0);

        // Hall call at floor 3 from floor 0; door dwell at 3.
        cyc(0, 4'b0, 4'b1000);
        chk("go_up_motor", bus.motor, 4'b0010);
        chk("go_up_dir", bus.dir_up, 1'b1);
        cyc(1, 4'b0, 4'b0); cyc(2, 4'b0, 4'b0); cyc(3, 4'b0, 4'b0);
        chk("door_at_3", bus.motor, 4'b1000);
        repeat (4) cyc(3, 4'b0, 4'b0);
        chk("idle_after_3", bus.motor, 4'b0001);

        // Car requests 2 and 1 held from floor 3.
        cyc(3, 4'b0110, 4'b0);
        chk("go_down", bus.motor, 4'b0100);
        repeat (4) cyc(2, 4'b0110, 4'b0);
        repeat (2) cyc(1, 4'b0110, 4'b0);
        repeat (6) cyc(1, 4'b0, 4'b0);

        // Simultaneous up/down from floor 1: up wins, then reverse.
        cyc(1, 4'b1001, 4'b0);
        chk("up_priority", bus.motor, 4'b0010);
        cyc(2, 4'b0, 4'b0); repeat (4) cyc(3, 4'b0, 4'b0);
        cyc(2, 4'b0, 4'b0); cyc(1, 4'b0, 4'b0); repeat (5) cyc(0, 4'b0, 4'b0);

        // Reset mid-move discards pending requests.
        cyc(0, 4'b1100, 4'b0);
        cyc(1, 4'b0, 4'b0);
        pulse_reset(1);
        chk("reset_mid_dir", bus.dir_up, 1'b0);
        repeat (3) cyc(1, 4'b0, 4'b0);
        chk("no_move_after_reset", bus.motor, 4'b0001);

        // Random traffic with a floor sensor doing a random walk.
        f = 1; bi = 4'b0; bo = 4'b0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) f = (f < 3) ? f + 1 : f;
                else                        f = (f > 0) ? f - 1 : f;
            end
            if ($urandom_range(2) != 0) begin
                bi = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0;
                bo = ($urandom_range(5) == 0) ? 4'($urandom) : 4'b0;
            end
            if ($urandom_range(499) == 0) pulse_reset($urandom_range(2));
            else cyc(f, bi, bo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
